// File: rtl/flit_slicer_buffered.sv
// rtl/flit_slicer_buffered.sv - flit slicer with independently drained address and data FIFOs
//
// flit_slicer_fifo : single-clock FIFO used once for each output field.
//   clk, reset : clock and asynchronous active-high reset
//   push, wdata: write wdata at the tail (caller guarantees not full)
//   pop        : remove the head (caller guarantees not empty)
//   head       : current head; holds the last popped value while empty
//   level      : current occupancy, 0..DEPTH
//
// flit_slicer_buffered : splits each accepted flit into address and data fields.
//   clk, reset                        : clock and asynchronous active-high reset
//   in_flit, in_valid, in_ready       : input flit handshake
//   addr_out, addr_valid, addr_ready  : address FIFO head and handshake
//   data_out, data_valid, data_ready  : data FIFO head and handshake
//   addr_level, data_level            : FIFO occupancies
//   flit_count                        : number of accepted flits, wrapping

module flit_slicer_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [W-1:0]     last_q;
    logic             nonempty;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign nonempty = (level != '0);

    // While empty, mem[rd_ptr] is a stale slot, so show the last popped value instead.
    assign head = nonempty ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                last_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage needs no reset: the level gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

module flit_slicer_buffered #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 7,
    parameter int DEPTH    = 2,
    parameter int ADDR_LSB = 1,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W+DATA_W-1:0]     in_flit,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ADDR_W-1:0]            addr_out,
    output logic                         addr_valid,
    input  logic                         addr_ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [$clog2(DEPTH+1)-1:0]   addr_level,
    output logic [$clog2(DEPTH+1)-1:0]   data_level,
    output logic [CNT_W-1:0]             flit_count
);

    localparam int FLIT_W = ADDR_W + DATA_W;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_field;
    logic [DATA_W-1:0] data_field;
    logic              accept;
    logic              addr_pop;
    logic              data_pop;

    generate
        if (ADDR_LSB != 0) begin : g_addr_low
            assign addr_field = in_flit[ADDR_W-1:0];
            assign data_field = in_flit[FLIT_W-1:ADDR_W];
        end else begin : g_addr_high
            assign addr_field = in_flit[FLIT_W-1:DATA_W];
            assign data_field = in_flit[DATA_W-1:0];
        end
    endgenerate

    // Ready depends only on registered levels, so a pop that frees a full FIFO
    // is seen one cycle later and no combinational path runs from the consumers.
    assign in_ready   = (addr_level < LVL_W'(DEPTH)) && (data_level < LVL_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign addr_valid = (addr_level != '0);
    assign data_valid = (data_level != '0);
    assign addr_pop   = addr_valid && addr_ready;
    assign data_pop   = data_valid && data_ready;

    flit_slicer_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (addr_field),
        .pop   (addr_pop),
        .head  (addr_out),
        .level (addr_level)
    );

    flit_slicer_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (data_field),
        .pop   (data_pop),
        .head  (data_out),
        .level (data_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_count <= '0;
        end else if (accept) begin
            flit_count <= flit_count + CNT_W'(1);
        end
    end

    // A stalled producer must keep its flit presented unchanged until taken.
    property p_producer_hold;
        @(posedge clk) disable iff (reset)
            (in_valid && !in_ready) |=> (in_valid && $stable(in_flit));
    endproperty
    a_producer_hold: assert property (p_producer_hold);

endmodule
